// File: rtl/req_encoder_pkg.sv
// Shared constants for the request encoder: FSM state codes, default sizes,
// and one-hot/binary conversion helpers.
package req_encoder_pkg;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  localparam int DEF_N = 4;
  localparam int DEF_W = 2;
  localparam int MAX_N = 32;

  function automatic logic [MAX_N-1:0] bin2onehot(input logic [4:0] bin);
    logic [MAX_N-1:0] oh;
    oh = '0;
    oh[bin] = 1'b1;
    return oh;
  endfunction

  // Multi-hot input returns the highest set index.
  function automatic logic [4:0] onehot2bin(input logic [MAX_N-1:0] oh);
    logic [4:0] bin;
    bin = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (oh[i]) bin = 5'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/req_encoder_prio_pick.sv
// Combinational winner search over the pending set, starting at a given index.
// DESCEND=1 walks start-1, start-2, ... (start=0 gives highest-index-first).
module prio_pick
  import req_encoder_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int W       = DEF_W,
  parameter bit DESCEND = 1'b1
) (
  input  logic [N-1:0] pend,
  input  logic [W-1:0] start,
  output logic [W-1:0] win,
  output logic         any
);

  logic [W-1:0] w_idx;
  logic         w_found;

  // W-bit arithmetic wraps modulo N, which gives the circular search order.
  always_comb begin
    win     = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (DESCEND) w_idx = start - W'(i);
      else         w_idx = start + W'(i - 1);
      if (!w_found && pend[w_idx]) begin
        win     = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign any = |pend;

endmodule

// File: rtl/req_encoder.sv
// Registered N-to-log2(N) request encoder with valid/ack handshake.
// Build option ROUND_ROBIN_EN selects round-robin instead of highest-index-first.
module req_encoder
  import req_encoder_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         En,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [W-1:0] code,
  output logic         valid,
  output logic [N-1:0] pend,
  output logic [0:0]   o_dbg_state
);

  // Handshake: code is offered while valid=1 and stays stable until the
  // consumer raises ack; the transfer happens on an edge with valid & ack.
  logic [0:0]   r_state;
  logic [W-1:0] r_code;
  logic         r_valid;
  logic [N-1:0] r_pend;

  logic         w_xfer;
  logic [N-1:0] w_clr;
  logic [W-1:0] w_start;
  logic [W-1:0] w_win;
  logic         w_any;

  assign w_xfer = r_valid & ack;
  assign w_clr  = w_xfer ? (N'(1) << r_code) : '0;

`ifdef ROUND_ROBIN_EN
  localparam bit PICK_DESCEND = 1'b0;
  logic [W-1:0] r_rr_ptr;

  always_ff @(posedge clk) begin
    if (rst)         r_rr_ptr <= '0;
    else if (w_xfer) r_rr_ptr <= r_code + W'(1);
  end

  assign w_start = r_rr_ptr;
`else
  localparam bit PICK_DESCEND = 1'b1;
  assign w_start = '0;
`endif

  prio_pick #(.N(N), .W(W), .DESCEND(PICK_DESCEND)) u_pick (
    .pend  (r_pend),
    .start (w_start),
    .win   (w_win),
    .any   (w_any)
  );

  // New requests OR in after the clear, so a re-asserted granted bit survives.
  always_ff @(posedge clk) begin
    if (rst) r_pend <= '0;
    else     r_pend <= (r_pend & ~w_clr) | (En ? req : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_code  <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_code  <= w_win;
            r_valid <= 1'b1;
            r_state <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (ack) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign code        = r_code;
  assign valid       = r_valid;
  assign pend        = r_pend;
  assign o_dbg_state = r_state;

endmodule
